// File: rtl/mod_74x163_cnt_if.sv
// Control/data bundle for the cascaded 74x163-style counter.
// DIR is only present when CNT_DOWN_EN is defined.
interface mod_74x163_cnt_if #(
  parameter int WIDTH = 4
);
  localparam int N = WIDTH / 4;

  logic             LD;
  logic [WIDTH-1:0] D;
  logic             ENP;
  logic             ENT;
`ifdef CNT_DOWN_EN
  logic             DIR;
`endif
  logic [WIDTH-1:0] Q;
  logic [N-1:0]     CO;
  logic             RCO;

  modport master (
    output LD, D, ENP, ENT,
`ifdef CNT_DOWN_EN
    output DIR,
`endif
    input  Q, CO, RCO
  );

  modport slave (
    input  LD, D, ENP, ENT,
`ifdef CNT_DOWN_EN
    input  DIR,
`endif
    output Q, CO, RCO
  );
endinterface

// File: rtl/mod_74x163_cnt.sv
// Presettable synchronous binary counter of WIDTH/4 cascaded 74x163 nibble stages.
// Q updates one cycle after sampled inputs; CO/RCO are combinational. Define CNT_DOWN_EN for up/down.
module mod_74x163_cnt #(
  parameter int WIDTH = 4
) (
  input logic              CLK,
  input logic              RST,
  mod_74x163_cnt_if.slave  bus
);
  localparam int N = WIDTH / 4;

  logic             up;
  logic [N-1:0]     t_en;
  logic [N-1:0]     co;
  logic [WIDTH-1:0] q;

`ifdef CNT_DOWN_EN
  assign up = bus.DIR;
`else
  assign up = 1'b1;
`endif

  for (genvar i = 0; i < N; i++) begin : g_stage
    logic [3:0] nib;
    logic       at_term;

    if (i == 0) begin : g_first
      assign t_en[i] = bus.ENT;
    end else begin : g_next
      assign t_en[i] = co[i-1];
    end

    // Terminal nibble is all-ones counting up, all-zeros counting down.
    assign at_term = up ? (nib == 4'hF) : (nib == 4'h0);
    assign co[i]   = t_en[i] & at_term;

    always_ff @(posedge CLK) begin
      if (RST) begin
        nib <= 4'h0;
      end else if (bus.LD) begin
        nib <= bus.D[4*i +: 4];
      end else if (bus.ENP && t_en[i]) begin
        nib <= up ? nib + 4'd1 : nib - 4'd1;
      end
    end

    assign q[4*i +: 4] = nib;
  end

  assign bus.Q   = q;
  assign bus.CO  = co;
  assign bus.RCO = co[N-1];
endmodule

// File: tb/tb_mod_74x163_cnt.sv
// Directed plus randomized checks of 4-bit and 8-bit counters against an arithmetic model.
// Down-count checks are compiled in when CNT_DOWN_EN is defined.
module tb_mod_74x163_cnt;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic       enp = 1'b0;
  logic       ent = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] d4 = 4'h0;
  logic [7:0] d8 = 8'h00;

  int checks = 0;
  int errors = 0;
  int m4 = 0;
  int m8 = 0;

  always #5 clk = ~clk;

  mod_74x163_cnt_if #(.WIDTH(4)) b4 ();
  mod_74x163_cnt_if #(.WIDTH(8)) b8 ();

  assign b4.LD  = ld;
  assign b4.D   = d4;
  assign b4.ENP = enp;
  assign b4.ENT = ent;
  assign b8.LD  = ld;
  assign b8.D   = d8;
  assign b8.ENP = enp;
  assign b8.ENT = ent;
`ifdef CNT_DOWN_EN
  assign b4.DIR = dir;
  assign b8.DIR = dir;
`endif

  mod_74x163_cnt #(.WIDTH(4)) dut4 (.CLK(clk), .RST(rst), .bus(b4));
  mod_74x163_cnt #(.WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(b8));

  function automatic bit cur_up();
`ifdef CNT_DOWN_EN
    return dir;
`else
    return 1'b1;
`endif
  endfunction

  // Next value of a flat w-bit counter from the operation priority rules.
  function automatic int next_val(int w, int q, int d);
    int mask = (1 << w) - 1;
    if (rst) return 0;
    if (ld) return d & mask;
    if (enp && ent) return cur_up() ? (q + 1) & mask : (q - 1) & mask;
    return q;
  endfunction

  // CO[i] is set when the low 4*(i+1) bits sit at the terminal value and ENT is high.
  function automatic int exp_co(int w, int q);
    int r = 0;
    for (int i = 0; i < w / 4; i++) begin
      int m = 1 << (4 * (i + 1));
      int lo = q % m;
      bit term = cur_up() ? (lo == m - 1) : (lo == 0);
      if (ent && term) r |= (1 << i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int c4 = exp_co(4, m4);
    int c8 = exp_co(8, m8);
    chk({tag, "_q4"}, int'(b4.Q), m4);
    chk({tag, "_co4"}, int'(b4.CO), c4);
    chk({tag, "_rco4"}, int'(b4.RCO), c4 & 1);
    chk({tag, "_q8"}, int'(b8.Q), m8);
    chk({tag, "_co8"}, int'(b8.CO), c8);
    chk({tag, "_rco8"}, int'(b8.RCO), (c8 >> 1) & 1);
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = next_val(4, m4, int'(d4));
    m8 = next_val(8, m8, int'(d8));
    #1;
  endtask

  initial begin
    // Reset held with load and count requested: D must never be loaded.
    rst = 1; ld = 1; d4 = 4'hA; d8 = 8'hA5; enp = 1; ent = 1; dir = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("reset_q", int'(b4.Q), 0);
      chk("reset_rco", int'(b4.RCO), 0);
      check_all("reset");
    end

    // Load wins over count.
    rst = 0; ld = 1; d4 = 4'h9; d8 = 8'h09;
    tick();
    chk("load_q", int'(b4.Q), 9);
    check_all("load");
    ld = 0;
    for (int k = 0; k < 3; k++) tick();
    chk("count3_q", int'(b4.Q), 'hC);
    check_all("count3");

    // Wrap and carry on the 4-bit counter.
    ld = 1; d4 = 4'hE; d8 = 8'h0E;
    tick();
    chk("wrapE_q", int'(b4.Q), 'hE);
    chk("wrapE_rco", int'(b4.RCO), 0);
    ld = 0;
    tick();
    chk("wrapF_q", int'(b4.Q), 'hF);
    chk("wrapF_rco", int'(b4.RCO), 1);
    chk("casc_0f_co", int'(b8.CO), 'b01);
    chk("casc_0f_rco", int'(b8.RCO), 0);
    ent = 0;
    #1;
    chk("ent0_rco", int'(b4.RCO), 0);
    check_all("ent0");
    ent = 1;
    tick();
    chk("wrap0_q", int'(b4.Q), 0);
    chk("wrap0_rco", int'(b4.RCO), 0);
    chk("casc_10_q", int'(b8.Q), 'h10);
    chk("casc_10_co", int'(b8.CO), 'b00);

    // Enable hold.
    ld = 1; d4 = 4'h5; d8 = 8'h55;
    tick();
    ld = 0; enp = 0; ent = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("hold_enp_q", int'(b4.Q), 5);
    enp = 1; ent = 0;
    tick();
    chk("hold_ent_q", int'(b4.Q), 5);
    chk("hold_ent_rco", int'(b4.RCO), 0);
    check_all("hold");

    // 8-bit all-ones carry and wrap.
    ld = 1; ent = 1; d4 = 4'hF; d8 = 8'hFF;
    tick();
    chk("casc_ff_co", int'(b8.CO), 'b11);
    chk("casc_ff_rco", int'(b8.RCO), 1);
    ld = 0;
    tick();
    chk("casc_00_q", int'(b8.Q), 0);
    check_all("casc");

`ifdef CNT_DOWN_EN
    rst = 1; enp = 0;
    tick();
    rst = 0; dir = 0; ent = 1;
    #1;
    chk("down_rco_at0", int'(b4.RCO), 1);
    check_all("down_rst");
    enp = 1;
    tick();
    chk("down_q", int'(b4.Q), 'hF);
    chk("down_rco", int'(b4.RCO), 0);
    tick();
    tick();
    rst = 1;
    tick();
    chk("down_midrst_q", int'(b4.Q), 0);
    check_all("down_midrst");
    rst = 0;
`endif

    // Randomized operation; carries re-checked right after inputs change.
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      enp = ($urandom_range(0, 3) != 0);
      ent = ($urandom_range(0, 3) != 0);
      d4  = 4'($urandom);
      d8  = 8'($urandom);
`ifdef CNT_DOWN_EN
      dir = 1'($urandom);
`endif
      #1;
      check_all("rnd_comb");
      tick();
      check_all("rnd_seq");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
